// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU instruction sequencer.
//   DW    : datapath width (matches the external ALU operands)
//   NREG  : register file depth, AW its address width
//   alu_op_e : 3-bit ALU opcode
//   instr_t  : packed 16-bit instruction word layout
//   state_e  : sequencer FSM states
package alu_pkg;

  localparam int DW   = 8;
  localparam int NREG = 4;
  localparam int AW   = $clog2(NREG);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SHL = 3'b010,
    OP_SHR = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_EQ  = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e    op;       // [15:13]
    logic [1:0] rd;       // [12:11]
    logic [1:0] rs1;      // [10:9]
    logic [1:0] rs2;      // [8:7]
    logic       imm_sel;  // [6]
    logic [5:0] imm;      // [5:0]
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// NREG x DW register file: one write port, two asynchronous read ports,
// cleared asynchronously by reset_n.
//   clk, reset_n           : clock / async active-low clear
//   we_i, waddr_i, wdata_i : write port
//   raddr_a_i, rdata_a_o   : read port A
//   raddr_b_i, rdata_b_o   : read port B
module alu_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (we_i) mem_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/alu_instr_sequencer.sv
// Multi-cycle front end for the external combinational 8-bit ALU.
// Accepts one instruction per 4 cycles, reads operands from the internal
// register file, drives the ALU, captures its result and writes it back.
//   clk, reset_n                    : clock / async active-low reset
//   instr_valid_i, instr_i,
//   instr_ready_o                   : instruction handshake
//   ld_en_i, ld_addr_i, ld_data_i   : register file load (IDLE only)
//   op_o, a_o, b_o                  : registered ALU control / operands
//   alu_res_i                       : ALU result
//   done_o, rd_o, result_o          : write-back pulse, destination, value
//
// state   | meaning
// IDLE    | ready for an instruction; register loads honoured
// DECODE  | operands read from register file / immediate
// EXEC    | ALU driven with held operands; result captured at cycle end
// WB      | result written to RF[rd]; done_o pulses
module alu_instr_sequencer
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          instr_valid_i,
  input  logic [15:0]   instr_i,
  output logic          instr_ready_o,
  input  logic          ld_en_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_data_i,
  output logic [2:0]    op_o,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o,
  input  logic [DW-1:0] alu_res_i,
  output logic          done_o,
  output logic [AW-1:0] rd_o,
  output logic [DW-1:0] result_o
);

  state_e        state_q, state_d;
  instr_t        instr_q, instr_d;
  alu_op_e       op_q, op_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [DW-1:0] result_q, result_d;
  logic [AW-1:0] rd_q, rd_d;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata_a, rf_rdata_b;

  // The single RF write port is shared: external loads in IDLE,
  // write-back in WB. The two can never collide.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    rd_d     = rd_q;
    rf_we    = 1'b0;
    rf_waddr = ld_addr_i;
    rf_wdata = ld_data_i;
    unique case (state_q)
      ST_IDLE: begin
        rf_we = ld_en_i;
        if (instr_valid_i) begin
          instr_d = instr_t'(instr_i);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        op_d    = instr_q.op;
        a_d     = rf_rdata_a;
        b_d     = instr_q.imm_sel ? DW'(instr_q.imm) : rf_rdata_b;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // result_o/rd_o are the capture registers themselves, so they are
        // valid in WB and hold until the next write-back.
        result_d = alu_res_i;
        rd_d     = instr_q.rd;
        state_d  = ST_WB;
      end
      ST_WB: begin
        rf_we    = 1'b1;
        rf_waddr = rd_q;
        rf_wdata = result_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  alu_regfile u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (instr_q.rs1),
    .raddr_b_i (instr_q.rs2),
    .rdata_a_o (rf_rdata_a),
    .rdata_b_o (rf_rdata_b)
  );

  // Gated with reset_n so the block never advertises ready while held in reset.
  assign instr_ready_o = (state_q == ST_IDLE) && reset_n;
  assign done_o        = (state_q == ST_WB);
  assign op_o          = op_q;
  assign a_o           = a_q;
  assign b_o           = b_q;
  assign rd_o          = rd_q;
  assign result_o      = result_q;

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
- Multi-cycle front end that drives the 8-bit combinational ALU.
- Accepts packed 16-bit instruction words over a valid/ready handshake and decodes each into an opcode and operands.
- Operands come from an internal 4x8 register file; the block drives the ALU control and operand inputs, captures the result, and writes it back.
- Sits between the instruction source (testbench or future fetch unit) and the ALU.

Parameters:
- DW, 8, datapath width; must match the ALU operand width.
- NREG, 4, register file depth; address width is log2(NREG) = 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- instr_valid_i  in  1  instruction word present.
- instr_i  in  16  instruction word.
- instr_ready_o  out  1  block can accept an instruction.
- ld_en_i  in  1  register file load strobe.
- ld_addr_i  in  2  register file load address.
- ld_data_i  in  8  register file load data.
- op_o  out  3  ALU opcode.
- a_o  out  8  ALU operand A.
- b_o  out  8  ALU operand B.
- alu_res_i  in  8  ALU result (combinational from op_o/a_o/b_o).
- done_o  out  1  one-cycle pulse marking write-back.
- rd_o  out  2  destination register of the completing instruction.
- result_o  out  8  value written back.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Instruction fields:
  - [15:13] opcode: 000 add, 001 sub, 010 shl, 011 shr, 100 and, 101 or, 110 xor, 111 eq.
  - [12:11] rd.
  - [10:9] rs1.
  - [8:7] rs2.
  - [6] imm_sel.
  - [5:0] imm.
- Operand selection: a = RF[rs1]. b = RF[rs2] if imm_sel=0, else {2'b00, imm}.
- FSM states: IDLE, DECODE, EXEC, WB.
  - IDLE: instr_ready_o=1. If instr_valid_i, latch instr_i and go to DECODE. Otherwise stay.
  - DECODE: read RF[rs1] and RF[rs2]/imm into operand registers. Go to EXEC.
  - EXEC: op_o/a_o/b_o hold the latched opcode and operands. Capture alu_res_i at the end of the cycle. Go to WB.
  - WB: write RF[rd] = captured result. done_o=1; rd_o and result_o valid. Go to IDLE.
- Timing: accept at cycle N, done_o in cycle N+3, instr_ready_o high again in N+4. Throughput is 1 instruction per 4 cycles.
- instr_ready_o is 0 in DECODE, EXEC and WB; instr_valid_i is ignored in those states.
- op_o/a_o/b_o are registered and held stable from DECODE exit through WB. They keep their last value in IDLE.
- Register file load:
  - Honoured only in IDLE; ignored in all other states.
  - A load in the same IDLE cycle as an instruction accept is written that cycle, so the DECODE read sees the new value.
  - Read-after-write across instructions: the next instruction's DECODE sees the prior WB value.
- Arithmetic is modulo 256; the carry/borrow is dropped. eq writes 8'h01 or 8'h00.
- Shifts use the full 8-bit b value; the ALU yields 0 for any shift of 8 or more.
- rd = rs1 or rd = rs2 is legal. Operands are captured in DECODE, so the write-back does not alter the current op.
- Reset (asynchronous, reset_n low, any state including mid-instruction):
  - FSM returns to IDLE; the in-flight instruction is discarded with no write-back.
  - RF cleared to 0.
  - op_o=0, a_o=0, b_o=0, rd_o=0, result_o=0, done_o=0.
  - instr_ready_o=1 once reset_n deasserts; it is 0 while reset_n is low.
- result_o and rd_o hold their values after the done_o pulse until the next WB.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum for the 3-bit opcodes.
  - instr_t packed struct for the field layout.
  - state_e for the FSM.
  - DW and NREG constants.
- One sub-module: alu_regfile (4x8, one write port, two async read ports, async clear), which shares the load and write-back port through a mux.
- The ALU itself stays external; the bench instantiates it and connects it to op_o/a_o/b_o/alu_res_i.

Test Plan:
- Reset mid-EXEC of add r0=r1+r2 -> no done_o; RF all 0; instr_ready_o=1 after reset_n rises; all outputs 0.
- Load r1=8'hF0, r2=8'h20; add r3=r1+r2 -> done_o 3 cycles after accept, rd_o=3, result_o=8'h10 (wrap); r3 reads back 8'h10.
- sub r0=r2-r1 with r1=8'h05, r2=8'h03 -> result_o=8'hFE. Then eq r1=r0 vs imm 6'h3E with imm_sel=1 -> result_o=8'h00. eq with r0 vs r0 -> 8'h01.
- shl r2=r1<<imm with r1=8'h81, imm=1 -> 8'h02. With imm=9 -> 8'h00. shr r1=r1>>imm with r1=8'h81, imm=7 -> 8'h01.
- Hold instr_valid_i high with two back-to-back words -> second accepted only in IDLE, 4 cycles after the first. No accept in DECODE/EXEC/WB. ld_en_i pulsed in EXEC is ignored, checked via RF readback.
- Same-cycle ld_en_i (r1=8'h0A) plus accept of xor r1=r1^imm 6'h0F -> result_o=8'h05. A dependent follow-on add r2=r1+r1 -> 8'h0A.
